// File: rtl/p2s_frame_scheduler.sv
// p2s_frame_scheduler
//   Round-robin scheduler that shares a single P2S serializer among N_CH byte
//   requesters. One requester is granted per frame. Its byte is presented on
//   P2S_DIN for the whole frame, and P2S_SOF pulses in the first cycle of the
//   frame. Frames are DW cycles long. When requests remain, frames run
//   back-to-back, so SOF arrives exactly every DW cycles.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active-high
//   EN         1 = new grants allowed; 0 = finish the current frame, then idle
//   REQ_VALID  per-channel byte valid
//   REQ_DATA   per-channel byte, channel i at [i*DW +: DW]
//   REQ_READY  per-channel accept, one-hot or zero, combinational
//   P2S_SOF    one-cycle start-of-frame pulse
//   P2S_DIN    byte being serialized, stable for the whole frame
//   CH_ID      channel index of the frame in flight
//   BUSY       high while a frame is being serialized
module p2s_frame_scheduler #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [N_CH-1:0]    REQ_VALID,
  input  logic [N_CH*DW-1:0] REQ_DATA,
  output logic [N_CH-1:0]    REQ_READY,
  output logic               P2S_SOF,
  output logic [DW-1:0]      P2S_DIN,
  output logic [CW-1:0]      CH_ID,
  output logic               BUSY
);

  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DW - 1);
  localparam logic [CW-1:0]   PtrLast = CW'(N_CH - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   ch_id_q, ch_id_d;
  logic [DW-1:0]   din_q, din_d;
  logic            sof_q, sof_d;

  logic            frame_last;
  logic            arb;
  logic [CW-1:0]   grant;
  logic            grant_found;
  logic [DW-1:0]   grant_data;

  // Last cycle of a frame is the only point inside SEND where a new grant may
  // be issued. This is what lets frames run back-to-back without a gap.
  assign frame_last = (state_q == StSend) && (bit_cnt_q == CntLast);

  // RST gates ARB so that REQ_READY stays low while reset is held.
  assign arb = !RST && EN && (|REQ_VALID) && ((state_q == StIdle) || frame_last);

  // Round-robin search. Two candidates are tracked:
  //   hi: the lowest valid index at or above rr_ptr (wraps last).
  //   lo: the lowest valid index overall (used after wrap-around).
  // The loop runs downwards, so the last assignment wins and gives the lowest
  // index.
  always_comb begin
    logic [CW-1:0] g_hi, g_lo;
    logic          found_hi, found_lo;
    g_hi     = '0;
    g_lo     = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (REQ_VALID[i]) begin
        g_lo     = CW'(i);
        found_lo = 1'b1;
        if (CW'(i) >= rr_ptr_q) begin
          g_hi     = CW'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant       = found_hi ? g_hi : g_lo;
    grant_found = found_lo;
  end

  // Byte mux and one-hot ready for the granted channel.
  always_comb begin
    grant_data = '0;
    REQ_READY  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CW'(i)) begin
        grant_data   = REQ_DATA[i*DW +: DW];
        REQ_READY[i] = arb;
      end
    end
  end

  // Next-state logic. A handshake is simply ARB with a found grant, because
  // REQ_READY is only raised on a channel whose VALID bit is set.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    ch_id_d   = ch_id_q;
    din_d     = din_q;
    sof_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
      end
      StSend: begin
        if (bit_cnt_q == CntLast) begin
          // End of frame: P2S_DIN and CH_ID keep their last values.
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
      end
    endcase

    if (arb && grant_found) begin
      din_d     = grant_data;
      ch_id_d   = grant;
      rr_ptr_d  = (grant == PtrLast) ? '0 : grant + CW'(1);
      sof_d     = 1'b1;
      bit_cnt_d = '0;
      state_d   = StSend;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rr_ptr_q  <= '0;
      ch_id_q   <= '0;
      din_q     <= '0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      ch_id_q   <= ch_id_d;
      din_q     <= din_d;
      sof_q     <= sof_d;
    end
  end

  assign P2S_SOF = sof_q;
  assign P2S_DIN = din_q;
  assign CH_ID   = ch_id_q;
  assign BUSY    = (state_q == StSend);

endmodule

// File: tb/tb_p2s_frame_scheduler.sv
module tb_p2s_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        p2s_sof;
  logic [7:0]  p2s_din;
  logic [2:0]  ch_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  p2s_frame_scheduler #(
    .N_CH(4),
    .DW  (8),
    .CW  (3)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .EN       (en),
    .REQ_VALID(req_valid),
    .REQ_DATA (req_data),
    .REQ_READY(req_ready),
    .P2S_SOF  (p2s_sof),
    .P2S_DIN  (p2s_din),
    .CH_ID    (ch_id),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Waits on negedges for a SOF pulse; n is the number of negedges waited.
  task automatic wait_sof(input int max_cyc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (p2s_sof) ok = 1'b1;
    end
  endtask

  // Short reset pulse that returns rr_ptr to 0.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (p2s_sof !== 1'b0) begin errors++; $display("FAIL reset_sof got=%b exp=0", p2s_sof); end
    checks++; if (p2s_din !== 8'h00) begin errors++; $display("FAIL reset_din got=%h exp=00", p2s_din); end
    checks++; if (ch_id !== 3'd0) begin errors++; $display("FAIL reset_ch_id got=%0d exp=0", ch_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    req_valid = 4'h0;
    rst       = 1'b0;
  endtask

  task automatic test_single_frame();
    @(negedge clk);
    req_data        = 32'h0;
    req_data[23:16] = 8'h9B;
    req_valid       = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    checks++; if (p2s_sof !== 1'b1) begin errors++; $display("FAIL single_sof got=%b exp=1", p2s_sof); end
    checks++; if (p2s_din !== 8'h9B) begin errors++; $display("FAIL single_din got=%h exp=9b", p2s_din); end
    checks++; if (ch_id !== 3'd2) begin errors++; $display("FAIL single_ch_id got=%0d exp=2", ch_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checks++; if (p2s_sof !== 1'b0) begin errors++; $display("FAIL single_sof_low cyc=%0d got=%b exp=0", i, p2s_sof); end
      checks++; if (busy !== 1'b1 || p2s_din !== 8'h9B) begin
        errors++; $display("FAIL single_hold cyc=%0d got busy=%b din=%h exp busy=1 din=9b", i, busy, p2s_din);
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    checks++; if (p2s_din !== 8'h9B || ch_id !== 3'd2) begin
      errors++; $display("FAIL single_idle_hold got din=%h ch=%0d exp din=9b ch=2", p2s_din, ch_id);
    end
  endtask

  task automatic test_round_robin();
    int n;
    bit ok;
    pulse_reset();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_sof((k == 0) ? 3 : 20, n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_sof_timeout idx=%0d got=none exp=sof", k); end
      if (ok) begin
        if (k > 0) begin
          checks++; if (n != 8) begin errors++; $display("FAIL rr_spacing idx=%0d got=%0d exp=8", k, n); end
        end
        checks++; if (ch_id !== 3'(k % 4)) begin errors++; $display("FAIL rr_ch_id idx=%0d got=%0d exp=%0d", k, ch_id, k % 4); end
        checks++; if (p2s_din !== 8'hA0 + 8'(k % 4)) begin
          errors++; $display("FAIL rr_din idx=%0d got=%h exp=%h", k, p2s_din, 8'hA0 + 8'(k % 4));
        end
      end
    end
    req_valid = 4'h0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle got=%b exp=0", busy); end
  endtask

  task automatic test_pointer_skip();
    int n;
    bit ok;
    pulse_reset();
    req_data  = 32'h3300_2211;
    req_valid = 4'b0010;
    wait_sof(3, n, ok);
    checks++; if (!ok || ch_id !== 3'd1) begin errors++; $display("FAIL skip_first got ok=%b ch=%0d exp ok=1 ch=1", ok, ch_id); end
    req_valid = 4'b1001;
    wait_sof(20, n, ok);
    checks++; if (!ok || n != 8) begin errors++; $display("FAIL skip_spacing1 got ok=%b n=%0d exp ok=1 n=8", ok, n); end
    checks++; if (ch_id !== 3'd3 || p2s_din !== 8'h33) begin
      errors++; $display("FAIL skip_ch3 got ch=%0d din=%h exp ch=3 din=33", ch_id, p2s_din);
    end
    wait_sof(20, n, ok);
    checks++; if (!ok || n != 8) begin errors++; $display("FAIL skip_spacing2 got ok=%b n=%0d exp ok=1 n=8", ok, n); end
    checks++; if (ch_id !== 3'd0 || p2s_din !== 8'h11) begin
      errors++; $display("FAIL skip_ch0 got ch=%0d din=%h exp ch=0 din=11", ch_id, p2s_din);
    end
    req_valid = 4'h0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_en_gating();
    int n;
    bit ok;
    pulse_reset();
    req_data  = 32'h0000_005A;
    req_valid = 4'b0001;
    en        = 1'b1;
    wait_sof(3, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_first_sof got=none exp=sof"); end
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_last_busy got=%b exp=1", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL en_last_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_idle got=%b exp=0", busy); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (p2s_sof !== 1'b0) begin errors++; $display("FAIL en_no_sof cyc=%0d got=%b exp=0", i, p2s_sof); end
    end
    en = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL en_resume_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    checks++; if (p2s_sof !== 1'b1 || ch_id !== 3'd0) begin
      errors++; $display("FAIL en_resume_sof got sof=%b ch=%0d exp sof=1 ch=0", p2s_sof, ch_id);
    end
    req_valid = 4'h0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit ok;
    pulse_reset();
    req_data  = 32'h00C3_0000;
    req_valid = 4'b0100;
    wait_sof(3, n, ok);
    req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    checks++; if (!ok || busy !== 1'b1 || p2s_din !== 8'hC3) begin
      errors++; $display("FAIL mid_pre got ok=%b busy=%b din=%h exp ok=1 busy=1 din=c3", ok, busy, p2s_din);
    end
    rst       = 1'b1;
    req_valid = 4'b0110;
    #1;
    checks++; if (p2s_din !== 8'h00 || ch_id !== 3'd0) begin
      errors++; $display("FAIL mid_rst_data got din=%h ch=%0d exp din=00 ch=0", p2s_din, ch_id);
    end
    checks++; if (busy !== 1'b0 || p2s_sof !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctrl got busy=%b sof=%b exp busy=0 sof=0", busy, p2s_sof);
    end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_release_ready got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = 4'h0;
    checks++; if (p2s_sof !== 1'b1 || ch_id !== 3'd1) begin
      errors++; $display("FAIL mid_release_grant got sof=%b ch=%0d exp sof=1 ch=1", p2s_sof, ch_id);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_pointer_skip();
    test_en_gating();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
